ppe_packet_rx: RTL and testbench



---
 rtl/ppe_packet_rx.sv | 166 ++++++++++++++++
 tb/tb_ppe_packet_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_packet_rx.sv
// ppe_packet_rx: responder end of the 4-phase bundled-data PE packet link.
// Synchronizes in_req, captures the packet, decodes address/opcode, assembles
// the five 8-bit weights from two weight packets and presents spike rows with
// the live weights on a valid/ready port.
// Optional feature: define PPE_RX_ADDR_CHECK_EN to drop packets whose address
// differs from MY_ADDR (acked, dropped, addr_err pulse). Without it the address
// field is ignored and addr_err stays 0.
module ppe_packet_rx #(
  parameter int WIDTH   = 30,
  parameter int ADDR_W  = 4,
  parameter int MY_ADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_spikes,
  output logic [39:0]      out_weights,
  output logic             weights_loaded,
  output logic             addr_err,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             req_meta;
  logic             req_s;
  logic [WIDTH-1:0] pkt;
  logic             wcnt;
  logic [7:0]       w0, w1, w2, w3, w4;
  logic             is_input;
  logic             addr_match;
  logic             load_row;
  logic             load_w;
  logic             drop_addr;
  logic             drop_seq;
  logic             ack_d;

  assign is_input    = pkt[WIDTH-ADDR_W-1];
  assign out_weights = {w4, w3, w2, w1, w0};

`ifdef PPE_RX_ADDR_CHECK_EN
  assign addr_match = (pkt[WIDTH-1 -: ADDR_W] == ADDR_W'(MY_ADDR));
`else
  logic unused_addr;
  assign addr_match  = 1'b1;
  assign unused_addr = ^{pkt[WIDTH-1 -: ADDR_W], (MY_ADDR != 0)};
`endif

  // Two-flop synchronizer bringing the asynchronous request into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= in_req;
      req_s    <= req_meta;
    end
  end

  // State register; the packet is latched on the IDLE->CAPTURE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pkt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_s) begin
        pkt <= in_data;
      end
    end
  end

  // Next-state decode and one-cycle action strobes for the datapath.
  always_comb begin
    next_state = state;
    load_row   = 1'b0;
    load_w     = 1'b0;
    drop_addr  = 1'b0;
    drop_seq   = 1'b0;
    ack_d      = in_ack;
    case (state)
      IDLE: begin
        if (req_s) next_state = CAPTURE;
      end
      CAPTURE: begin
        if (!addr_match) begin
          drop_addr  = 1'b1;
          next_state = ACK;
        end else if (!is_input) begin
          load_w     = 1'b1;
          next_state = ACK;
        end else if (!weights_loaded) begin
          drop_seq   = 1'b1;
          next_state = ACK;
        end else if (out_valid && !out_ready) begin
          next_state = CAPTURE;
        end else begin
          load_row   = 1'b1;
          next_state = ACK;
        end
        if (next_state == ACK) ack_d = 1'b1;
      end
      ACK: begin
        if (!req_s) next_state = RELEASE;
      end
      RELEASE: begin
        ack_d      = 1'b0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Acknowledge, error pulses, weight assembly and the output row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack         <= 1'b0;
      addr_err       <= 1'b0;
      seq_err        <= 1'b0;
      wcnt           <= 1'b0;
      weights_loaded <= 1'b0;
      w0             <= '0;
      w1             <= '0;
      w2             <= '0;
      w3             <= '0;
      w4             <= '0;
      out_valid      <= 1'b0;
      out_spikes     <= '0;
    end else begin
      in_ack   <= ack_d;
      addr_err <= drop_addr;
      seq_err  <= drop_seq;
      if (load_w) begin
        if (!wcnt) begin
          w0   <= pkt[7:0];
          w1   <= pkt[15:8];
          w2   <= pkt[23:16];
          wcnt <= 1'b1;
        end else begin
          w3             <= pkt[7:0];
          w4             <= pkt[15:8];
          wcnt           <= 1'b0;
          weights_loaded <= 1'b1;
        end
      end
      if (load_row) begin
        out_spikes <= pkt[24:0];
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppe_packet_rx.sv
// Testbench for ppe_packet_rx: directed packets through a 4-phase sender,
// expected rows and error pulses queued at stimulus time and consumed by an
// independent monitor.
module tb_ppe_packet_rx;

  typedef struct {
    logic [24:0] spikes;
    logic [39:0] weights;
  } row_t;

  localparam int BUDGET = 300;

  logic        clk;
  logic        rst_n;
  logic        in_req;
  logic [29:0] in_data;
  logic        in_ack;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_spikes;
  logic [39:0] out_weights;
  logic        weights_loaded;
  logic        addr_err;
  logic        seq_err;

  int   checks   = 0;
  int   failures = 0;
  row_t rowQ[$];
  logic [1:0] errQ[$];

  ppe_packet_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_req         (in_req),
    .in_data        (in_data),
    .in_ack         (in_ack),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_spikes     (out_spikes),
    .out_weights    (out_weights),
    .weights_loaded (weights_loaded),
    .addr_err       (addr_err),
    .seq_err        (seq_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ack to reach level v, sampling 1 unit after posedge.
  task automatic waitAck(input logic v, input string name, output int cycles);
    cycles = 0;
    while (in_ack !== v && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput(name, {63'd0, in_ack}, {63'd0, v});
  endtask

  // One complete 4-phase transfer; returns the rise and fall latencies.
  task automatic applyStimulus(input logic [29:0] p, output int riseCyc,
                               output int fallCyc);
    in_data = p;
    in_req  = 1'b1;
    waitAck(1'b1, "ack_rise", riseCyc);
    in_req = 1'b0;
    waitAck(1'b0, "ack_fall", fallCyc);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: consumes queued expectations whenever the DUT presents output.
  initial begin : monitor
    row_t       e;
    logic [1:0] ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (rowQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_row: got spikes %0h expected none", out_spikes);
          end else begin
            e = rowQ.pop_front();
            checkOutput("row_spikes", {39'd0, out_spikes}, {39'd0, e.spikes});
            checkOutput("row_weights", {24'd0, out_weights}, {24'd0, e.weights});
          end
        end
        if (addr_err || seq_err) begin
          if (errQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_err: got addr_err=%0b seq_err=%0b expected none",
                     addr_err, seq_err);
          end else begin
            ee = errQ.pop_front();
            checkOutput("err_kind", {62'd0, addr_err, seq_err}, {62'd0, ee});
            checkOutput("err_with_ack", {63'd0, in_ack}, 64'd1);
          end
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    int r, f;
    logic [39:0] wExp;
    rst_n     = 1'b0;
    in_req    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_in_ack", {63'd0, in_ack}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_spikes", {39'd0, out_spikes}, 64'd0);
    checkOutput("rst_weights", {24'd0, out_weights}, 64'd0);
    checkOutput("rst_loaded", {63'd0, weights_loaded}, 64'd0);
    checkOutput("rst_errs", {62'd0, addr_err, seq_err}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] input packet before weights");
    errQ.push_back(2'b01);
    applyStimulus({4'd5, 1'b1, 25'h1555555}, r, f);
    checkOutput("early_no_valid", {63'd0, out_valid}, 64'd0);

    $display("[TB] weight pair");
    applyStimulus({4'd5, 1'b0, 1'b0, 8'h03, 8'h02, 8'h01}, r, f);
    checkOutput("half_not_loaded", {63'd0, weights_loaded}, 64'd0);
    applyStimulus({4'd5, 1'b0, 1'b0, 8'h06, 8'h05, 8'h04}, r, f);
    wExp = 40'h0504030201;
    checkOutput("weights", {24'd0, out_weights}, {24'd0, wExp});
    checkOutput("weights_loaded", {63'd0, weights_loaded}, 64'd1);

    $display("[TB] input row with ready high");
    rowQ.push_back('{spikes: 25'h0AAAAAA, weights: wExp});
    applyStimulus({4'd5, 1'b1, 25'h0AAAAAA}, r, f);
    checkOutput("ack_rise_latency", r, 64'd4);
    checkOutput("ack_fall_latency", f, 64'd4);
    checkOutput("valid_cleared", {63'd0, out_valid}, 64'd0);

    $display("[TB] backpressure with two rows");
    out_ready = 1'b0;
    rowQ.push_back('{spikes: 25'h1234567, weights: wExp});
    rowQ.push_back('{spikes: 25'h1C0FFEE, weights: wExp});
    applyStimulus({4'd5, 1'b1, 25'h1234567}, r, f);
    checkOutput("row1_held", {63'd0, out_valid}, 64'd1);
    fork
      applyStimulus({4'd5, 1'b1, 25'h1C0FFEE}, r, f);
      begin
        repeat (20) begin
          @(posedge clk);
          #1;
        end
        checkOutput("stall_no_ack", {63'd0, in_ack}, 64'd0);
        checkOutput("stall_row1", {39'd0, out_spikes}, 64'h1234567);
        out_ready = 1'b1;
      end
    join
    checkOutput("stall_drained", {63'd0, out_valid}, 64'd0);

    $display("[TB] packet for address 3");
`ifdef PPE_RX_ADDR_CHECK_EN
    errQ.push_back(2'b10);
    applyStimulus({4'd3, 1'b0, 1'b0, 8'h09, 8'h08, 8'h07}, r, f);
    checkOutput("addr3_weights", {24'd0, out_weights}, 64'h0504030201);
`else
    applyStimulus({4'd3, 1'b0, 1'b0, 8'h09, 8'h08, 8'h07}, r, f);
    checkOutput("addr3_weights", {24'd0, out_weights}, 64'h0504090807);
`endif
    checkOutput("addr3_loaded", {63'd0, weights_loaded}, 64'd1);

    $display("[TB] reset during acknowledge");
    out_ready = 1'b0;
    in_data   = {4'd5, 1'b1, 25'h0123456};
    in_req    = 1'b1;
    waitAck(1'b1, "mid_ack_rise", r);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack", {63'd0, in_ack}, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_weights", {24'd0, out_weights}, 64'd0);
    checkOutput("mid_rst_loaded", {63'd0, weights_loaded}, 64'd0);
    @(posedge clk);
    #1;
    errQ.push_back(2'b01);
    rst_n = 1'b1;
    waitAck(1'b1, "recap_ack_rise", r);
    in_req = 1'b0;
    waitAck(1'b0, "recap_ack_fall", f);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("recap_no_valid", {63'd0, out_valid}, 64'd0);

    checkOutput("rows_consumed", rowQ.size(), 64'd0);
    checkOutput("errs_consumed", errQ.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
